// File: rtl/audio_pkg.sv
// Shared types for the codec audio path: sample width, stereo frame layout
// and the DAC transmitter frame states.
package audio_pkg;

   localparam int AUDIO_DATA_W = 24;

   typedef struct packed {
      logic [AUDIO_DATA_W-1:0] left;
      logic [AUDIO_DATA_W-1:0] right;
   } stereo_frame_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_LEFT  = 2'd1,
      TX_RIGHT = 2'd2
   } dac_tx_state_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Show-ahead synchronous FIFO of stereo frames. A pop frees a slot for a
// push in the same cycle, so push+pop while full keeps the level at DEPTH.
module audio_frame_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   ck,
   input  logic                   rst_n,
   input  logic                   push,
   input  stereo_frame_t          push_data,
   input  logic                   pop,
   output stereo_frame_t          pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   stereo_frame_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_nxt;
   logic             do_push;
   logic             do_pop;

   assign empty    = (level == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
   always_comb begin
      level_nxt = level;
      if (do_push && !do_pop)
         level_nxt = level + 1'b1;
      else if (do_pop && !do_push)
         level_nxt = level - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         full  <= (level_nxt == LVL_W'(DEPTH));
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and level define which entries are valid.
   always_ff @(posedge ck) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/audio_dac_tx.sv
// WM8731 DAC serialiser: buffers stereo frames and shifts them out MSB-first,
// left-justified, against the codec-mastered bit and frame clocks.
module audio_dac_tx
   import audio_pkg::*;
#(
   parameter int DATA_W     = AUDIO_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        ck,
   input  logic                        rst_n,
   input  logic                        write,
   input  logic [DATA_W-1:0]           writedata_left,
   input  logic [DATA_W-1:0]           writedata_right,
   output logic                        write_ready,
   input  logic                        aud_bclk,
   input  logic                        aud_daclrck,
   output logic                        aud_dacdat,
   output logic                        underflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [1:0]        bclk_sync;
   logic [1:0]        lrck_sync;
   logic              bclk_d;
   logic              bclk_fall;
   logic              lrck;
   logic              lrck_q;
   logic              lrck_rise;
   logic              lrck_fall;

   dac_tx_state_t     state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] rbuf;
   logic [CNT_W-1:0]  bit_cnt;

   stereo_frame_t     push_frame;
   stereo_frame_t     pop_frame;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   // Both codec clocks see identical synchroniser latency, so LRCK stays aligned to BCLK.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         bclk_d    <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], aud_bclk};
         lrck_sync <= {lrck_sync[0], aud_daclrck};
         bclk_d    <= bclk_sync[1];
      end
   end

   assign bclk_fall = bclk_d && !bclk_sync[1];
   assign lrck      = lrck_sync[1];
   assign lrck_rise = lrck && !lrck_q;
   assign lrck_fall = !lrck && lrck_q;

   assign push_frame  = '{left: writedata_left, right: writedata_right};
   assign fifo_pop    = bclk_fall && lrck_rise && !fifo_empty;
   assign write_ready = !fifo_full;

   audio_frame_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .ck        (ck),
      .rst_n     (rst_n),
      .push      (write),
      .push_data (push_frame),
      .pop       (fifo_pop),
      .pop_data  (pop_frame),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // lrck_q resets high so a frame can only start after a genuine LRCK 0->1.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state      <= TX_IDLE;
         lrck_q     <= 1'b1;
         shreg      <= '0;
         rbuf       <= '0;
         bit_cnt    <= '0;
         aud_dacdat <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         underflow <= 1'b0;
         if (bclk_fall) begin
            lrck_q <= lrck;
            if (lrck_rise) begin
               state   <= TX_LEFT;
               bit_cnt <= CNT_W'(1);
               if (!fifo_empty) begin
                  shreg      <= pop_frame.left;
                  rbuf       <= pop_frame.right;
                  aud_dacdat <= pop_frame.left[DATA_W-1];
               end else begin
                  shreg      <= '0;
                  rbuf       <= '0;
                  aud_dacdat <= 1'b0;
                  underflow  <= 1'b1;
               end
            end else begin
               case (state)
                  TX_IDLE: aud_dacdat <= 1'b0;
                  TX_LEFT, TX_RIGHT: begin
                     if (state == TX_LEFT && lrck_fall) begin
                        state      <= TX_RIGHT;
                        shreg      <= rbuf;
                        aud_dacdat <= rbuf[DATA_W-1];
                        bit_cnt    <= CNT_W'(1);
                     end else if (bit_cnt < CNT_W'(DATA_W)) begin
                        shreg      <= {shreg[DATA_W-2:0], 1'b0};
                        aud_dacdat <= shreg[DATA_W-2];
                        bit_cnt    <= bit_cnt + 1'b1;
                     end else begin
                        aud_dacdat <= 1'b0;
                     end
                  end
                  default: state <= TX_IDLE;
               endcase
            end
         end
      end
   end

endmodule
